// File: rtl/bin2bcd_digits_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
// The master drives the conversion request; the slave returns status and display nibbles.
interface bin2bcd_digits_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  blankEn;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic [4*DIGITS-1:0]   digits;

  modport master (
    output start, bin, blankEn,
    input  busy, done, ovf, digits
  );

  modport slave (
    input  start, bin, blankEn,
    output busy, done, ovf, digits
  );
endinterface

// File: rtl/bin2bcd_digits.sv
// Shift-and-add-3 binary to BCD converter, one input bit per clock, with leading-zero
// blanking (4'hF) and an all-4'hE overflow pattern for the downstream 7-segment decoders.
module bin2bcd_digits #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic           clk,
  input  logic           rstN,
  bin2bcd_digits_if.slave bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } stateT;

  stateT              state;
  stateT              stateNext;
  logic [BIN_W-1:0]   binReg;
  logic [BCD_W-1:0]   bcdReg;
  logic [BCD_W-1:0]   bcdAdj;
  logic [BCD_W-1:0]   bcdShift;
  logic [BCD_W-1:0]   digitsReg;
  logic [BCD_W-1:0]   digitsFmt;
  logic [CNT_W-1:0]   bitCnt;
  logic               ovfSticky;
  logic               ovfReg;
  logic               blankReg;
  logic               carryOut;
  logic               accept;
  logic               shiftEn;
  logic               finish;
  logic               leading;
  logic [3:0]         nib;

  // Add-3 correction per nibble, then the whole {bcd, bin} pair moves left one bit.
  always_comb begin
    bcdAdj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcdReg[4*i +: 4] >= 4'd5) begin
        bcdAdj[4*i +: 4] = bcdReg[4*i +: 4] + 4'd3;
      end else begin
        bcdAdj[4*i +: 4] = bcdReg[4*i +: 4];
      end
    end
    bcdShift = {bcdAdj[BCD_W-2:0], binReg[BIN_W-1]};
    carryOut = bcdAdj[BCD_W-1];
  end

  // Display formatting of the finished scratch value: overflow pattern or blanked/raw BCD.
  always_comb begin
    digitsFmt = bcdReg;
    leading   = blankReg;
    nib       = 4'h0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      nib = bcdReg[4*i +: 4];
      if (leading && (nib == 4'h0)) begin
        digitsFmt[4*i +: 4] = 4'hF;
      end else begin
        leading = 1'b0;
      end
    end
    if (ovfSticky) begin
      digitsFmt = {DIGITS{4'hE}};
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Shifting continues while the counter is nonzero; the edge that finds it at zero
  // publishes the formatted result and enters DONE.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    shiftEn   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          stateNext = SHIFT;
        end
      end
      SHIFT: begin
        if (bitCnt != '0) begin
          shiftEn = 1'b1;
        end else begin
          finish    = 1'b1;
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      binReg    <= '0;
      bcdReg    <= '0;
      bitCnt    <= '0;
      ovfSticky <= 1'b0;
      blankReg  <= 1'b0;
      digitsReg <= {DIGITS{4'hF}};
      ovfReg    <= 1'b0;
    end else begin
      if (accept) begin
        binReg    <= bus.bin;
        bcdReg    <= '0;
        bitCnt    <= CNT_W'(BIN_W);
        ovfSticky <= 1'b0;
        blankReg  <= bus.blankEn;
      end else if (shiftEn) begin
        binReg    <= {binReg[BIN_W-2:0], 1'b0};
        bcdReg    <= bcdShift;
        bitCnt    <= bitCnt - CNT_W'(1);
        ovfSticky <= ovfSticky | carryOut;
      end
      if (finish) begin
        digitsReg <= digitsFmt;
        ovfReg    <= ovfSticky;
      end
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.ovf    = ovfReg;
  assign bus.digits = digitsReg;

endmodule

// File: tb/tb_bin2bcd_digits.sv
// Directed plus random checks of bin2bcd_digits (5-digit and 4-digit builds) against
// a decimal-arithmetic reference of the displayed digits.
module tb_bin2bcd_digits;

  logic clk;
  logic rstN;
  int   checks;
  int   errors;

  bin2bcd_digits_if #(.BIN_W(16), .DIGITS(5)) bus5 ();
  bin2bcd_digits_if #(.BIN_W(16), .DIGITS(4)) bus4 ();

  bin2bcd_digits #(.BIN_W(16), .DIGITS(5)) dut5 (.clk(clk), .rstN(rstN), .bus(bus5.slave));
  bin2bcd_digits #(.BIN_W(16), .DIGITS(4)) dut4 (.clk(clk), .rstN(rstN), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected display: decimal digits by division, overflow pattern, leading-zero blanking.
  function automatic logic [19:0] modelDigits(input int unsigned v, input int d, input bit blank,
                                              output bit ovf);
    logic [19:0]  r;
    int unsigned  pow;
    int unsigned  rem;
    bit           lead;
    r   = '0;
    pow = 1;
    for (int i = 0; i < d; i++) pow = pow * 10;
    ovf = (v >= pow);
    rem = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = ovf ? 4'hE : 4'(rem % 10);
      rem = rem / 10;
    end
    if (!ovf && blank) begin
      lead = 1'b1;
      for (int i = d - 1; i >= 1; i--) begin
        if (lead && r[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One full conversion on the chosen build, checking accept, latency, result and pulse width.
  task automatic applyStimulus(input bit sel4, input int unsigned v, input bit blank, input string tag);
    logic [19:0] expDigits;
    bit          expOvf;
    int          n;
    logic        seenDone;
    expDigits = modelDigits(v, sel4 ? 4 : 5, blank, expOvf);
    @(negedge clk);
    if (sel4) begin
      bus4.start = 1'b1; bus4.bin = 16'(v); bus4.blankEn = blank;
    end else begin
      bus5.start = 1'b1; bus5.bin = 16'(v); bus5.blankEn = blank;
    end
    @(posedge clk);
    #1;
    bus4.start = 1'b0;
    bus5.start = 1'b0;
    checkOutput({tag, "-busy"}, 32'(sel4 ? bus4.busy : bus5.busy), 32'd1);
    n = 0;
    seenDone = 1'b0;
    while (!seenDone && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      seenDone = sel4 ? bus4.done : bus5.done;
    end
    checkOutput({tag, "-latency"}, 32'(n), 32'd17);
    checkOutput({tag, "-digits"}, sel4 ? 32'(bus4.digits) : 32'(bus5.digits), 32'(expDigits));
    checkOutput({tag, "-ovf"}, 32'(sel4 ? bus4.ovf : bus5.ovf), 32'(expOvf));
    @(posedge clk);
    #1;
    checkOutput({tag, "-donePulse"}, 32'(sel4 ? bus4.done : bus5.done), 32'd0);
    checkOutput({tag, "-idle"}, 32'(sel4 ? bus4.busy : bus5.busy), 32'd0);
  endtask

  initial begin
    int          doneCount;
    int          doneAt;
    int unsigned v;
    bit          b;
    checks = 0;
    errors = 0;
    bus5.start = 1'b0; bus5.bin = '0; bus5.blankEn = 1'b0;
    bus4.start = 1'b0; bus4.bin = '0; bus4.blankEn = 1'b0;
    rstN = 1'b0;
    #23;
    checkOutput("rst-digits5", 32'(bus5.digits), 32'h000FFFFF);
    checkOutput("rst-busy5", 32'(bus5.busy), 32'd0);
    checkOutput("rst-done5", 32'(bus5.done), 32'd0);
    checkOutput("rst-ovf5", 32'(bus5.ovf), 32'd0);
    checkOutput("rst-digits4", 32'(bus4.digits), 32'h0000FFFF);
    @(negedge clk);
    rstN = 1'b1;

    applyStimulus(1'b0, 12345, 1'b0, "d12345");
    applyStimulus(1'b0, 42, 1'b1, "blank42");
    applyStimulus(1'b0, 0, 1'b1, "blank0");
    applyStimulus(1'b0, 10005, 1'b1, "blank10005");
    applyStimulus(1'b0, 65535, 1'b0, "max5");
    applyStimulus(1'b0, 42, 1'b0, "raw42");
    applyStimulus(1'b1, 9999, 1'b0, "d4-9999");
    applyStimulus(1'b1, 10000, 1'b0, "d4-10000");
    applyStimulus(1'b1, 10000, 1'b1, "d4-ovfBlank");
    applyStimulus(1'b1, 305, 1'b1, "d4-blank305");

    repeat (5) @(posedge clk);
    #1;
    checkOutput("hold-digits", 32'(bus5.digits), 32'h00000042);

    // Requests during a conversion are dropped; only the first value is converted.
    @(negedge clk);
    bus5.start = 1'b1; bus5.bin = 16'd7; bus5.blankEn = 1'b0;
    @(posedge clk);
    #1;
    bus5.start = 1'b0;
    doneCount = 0;
    doneAt = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c >= 3 && c <= 10) begin
        bus5.start = 1'b1; bus5.bin = 16'd99;
      end else begin
        bus5.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus5.done) begin
        doneCount++;
        doneAt = c;
      end
    end
    bus5.start = 1'b0;
    checkOutput("ignore-doneCount", 32'(doneCount), 32'd1);
    checkOutput("ignore-doneAt", 32'(doneAt), 32'd17);
    checkOutput("ignore-digits", 32'(bus5.digits), 32'h00000007);

    // Abort part way through a conversion.
    @(negedge clk);
    bus5.start = 1'b1; bus5.bin = 16'd12345; bus5.blankEn = 1'b0;
    @(posedge clk);
    #1;
    bus5.start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("abort-digits", 32'(bus5.digits), 32'h000FFFFF);
    checkOutput("abort-busy", 32'(bus5.busy), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    doneCount = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (bus5.done) doneCount++;
    end
    checkOutput("abort-noDone", 32'(doneCount), 32'd0);
    applyStimulus(1'b0, 808, 1'b0, "afterAbort");

    for (int k = 0; k < 16; k++) begin
      v = $urandom_range(0, 65535);
      b = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, v, b, $sformatf("rand5-%0d", k));
    end
    for (int k = 0; k < 10; k++) begin
      v = (k % 2 == 0) ? $urandom_range(0, 9999) : $urandom_range(0, 65535);
      b = 1'($urandom_range(0, 1));
      applyStimulus(1'b1, v, b, $sformatf("rand4-%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
